// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, mux selects,
// opcode/condition/command constants and the condition-check helper.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCA_REG = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // flags is {N,Z,C,V}; the 1111 encoding never executes.
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, res;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = !z;
      COND_CS: res = c;
      COND_CC: res = !c;
      COND_MI: res = n;
      COND_PL: res = !n;
      COND_VS: res = v;
      COND_VC: res = !v;
      COND_HI: res = c & !z;
      COND_LS: res = !c | z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = !z & (n == v);
      COND_LE: res = z | (n != v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cond_unit.sv
// Registered NZCV flags, condition evaluation and gating of the architectural
// write enables; every enable is held low while reset is asserted.
module cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite
);

  logic [3:0] flags_reg;
  logic       cond_ex;

  assign cond_ex = cond_holds(cond, flags_reg);

  // FlagW[1] covers N,Z; FlagW[0] covers C,V so logical ops leave C,V alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_reg <= 4'b0000;
    end else begin
      if (FlagW[1] && cond_ex) flags_reg[3:2] <= ALUFlags[3:2];
      if (FlagW[0] && cond_ex) flags_reg[1:0] <= ALUFlags[1:0];
    end
  end

  assign PCWrite  = reset & (NextPC | (PCS & cond_ex));
  assign RegWrite = reset & RegW & cond_ex;
  assign MemWrite = reset & MemW & cond_ex;

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: instruction-sequencing FSM and ALU decoder,
// with flag storage and write gating delegated to cond_unit.
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
);

  state_t state_reg, state_next, state_eff;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic       rd_pc;
  logic       unused_instr;

  logic       next_pc, reg_w, mem_w, branch, ir_write, alu_decode;
  logic [1:0] alu_dec, flag_w_dec, flag_w;

  assign cond         = Instr[31:28];
  assign op           = Instr[27:26];
  assign funct        = Instr[25:20];
  assign rd_pc        = (Instr[15:12] == 4'd15);
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= FETCH;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:    state_next = DECODE;
      DECODE: begin
        case (op)
          OP_DP:   state_next = funct[5] ? EXECUTEI : EXECUTER;
          OP_MEM:  state_next = MEMADR;
          OP_BR:   state_next = BRANCH;
          default: state_next = UNKNOWN;
        endcase
      end
      MEMADR:   state_next = funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_next = MEMWB;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      UNKNOWN:  state_next = UNKNOWN;
      default:  state_next = FETCH;
    endcase
  end

  // While reset is asserted the mux selects present FETCH values.
  assign state_eff = reset ? state_reg : FETCH;

  always_comb begin
    next_pc    = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    alu_decode = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_REG;
    ALUSrcB    = SRCB_WD;
    ResultSrc  = RES_ALUOUT;
    case (state_eff)
      FETCH: begin
        ir_write  = 1'b1;
        next_pc   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      MEMADR:   ALUSrcB = SRCB_IMM;
      MEMRD:    AdrSrc  = 1'b1;
      MEMWB: begin
        reg_w     = 1'b1;
        ResultSrc = RES_DATA;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      EXECUTER: alu_decode = 1'b1;
      EXECUTEI: begin
        alu_decode = 1'b1;
        ALUSrcB    = SRCB_IMM;
      end
      ALUWB:    reg_w = 1'b1;
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // Unrecognised commands still add, but never touch the flags.
  always_comb begin
    alu_dec    = ALU_ADD;
    flag_w_dec = 2'b00;
    case (funct[4:1])
      CMD_ADD: begin alu_dec = ALU_ADD; flag_w_dec = {2{funct[0]}}; end
      CMD_SUB: begin alu_dec = ALU_SUB; flag_w_dec = {2{funct[0]}}; end
      CMD_AND: begin alu_dec = ALU_AND; flag_w_dec = {funct[0], 1'b0}; end
      CMD_ORR: begin alu_dec = ALU_ORR; flag_w_dec = {funct[0], 1'b0}; end
      default: ;
    endcase
  end

  assign ALUControl = alu_decode ? alu_dec : ALU_ADD;
  assign flag_w     = alu_decode ? flag_w_dec : 2'b00;
  assign IRWrite    = reset & ir_write;
  assign ImmSrc     = op;
  assign RegSrc     = {op == OP_MEM, op == OP_BR};

  cond_unit u_cond (
    .clk      (clk),
    .reset    (reset),
    .cond     (cond),
    .ALUFlags (ALUFlags),
    .FlagW    (flag_w),
    .PCS      (branch | (reg_w & rd_pc)),
    .NextPC   (next_pc),
    .RegW     (reg_w & !rd_pc),
    .MemW     (mem_w),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite)
  );

endmodule
